// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared scan-state enum, nibble width and digit-selection helpers for the seven-segment scanner.
package seven_seg_pkg;
    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} scan_state_t;
    localparam int NIBBLE_W   = 4;
    localparam int MAX_DIGITS = 8;
    function automatic logic [NIBBLE_W-1:0] nib_sel(input logic [NIBBLE_W*MAX_DIGITS-1:0] value, input logic [2:0] idx);
        return value[idx*NIBBLE_W +: NIBBLE_W];
    endfunction
    // Index of the most-significant nonzero nibble; 0 for an all-zero value.
    function automatic logic [2:0] msd_idx(input logic [NIBBLE_W*MAX_DIGITS-1:0] value);
        msd_idx = '0;
        for (int i = 1; i < MAX_DIGITS; i++)
            if (value[i*NIBBLE_W +: NIBBLE_W] != '0) msd_idx = 3'(i);
    endfunction
endpackage

// File: rtl/seven_seg_slot_timer.sv
// seven_seg_slot_timer: reloadable down-counter; pulses o_Expire during the last cycle of a loaded interval.
module seven_seg_slot_timer
    import seven_seg_pkg::*;
#(
    parameter int CW = 3
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    input  logic          i_Load,
    input  logic [CW-1:0] i_Load_Val,
    output logic          o_Expire
);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;
    assign o_Expire = armed_q && (cnt_q == '0);
    always_comb begin
        cnt_d   = i_Load ? i_Load_Val - CW'(1) : (cnt_q != '0 ? cnt_q - CW'(1) : cnt_q);
        armed_d = i_Load | (armed_q & ~o_Expire);
    end
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: blanked, double-buffered digit scanner for a shared registered 7-segment decoder.
// Define LEADING_ZERO_BLANK_EN to keep digits above the most-significant nonzero nibble dark.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int DRIVE_CYCLES = 25000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst,
    input  logic                         i_Enable,
    input  logic [NIBBLE_W*N_DIGITS-1:0] i_Value,
    input  logic                         i_Value_Load,
    output logic                         o_Load_Pending,
    output logic [NIBBLE_W-1:0]          o_Nibble,
    output logic [N_DIGITS-1:0]          o_Digit_En,
    output logic                         o_Frame_Done
);
    localparam int IW   = $clog2(N_DIGITS);
    localparam int MAXC = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int VW   = NIBBLE_W * N_DIGITS;

    scan_state_t         state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [VW-1:0]       shadow_q, shadow_d, hold_q, hold_d;
    logic                pend_q, pend_d, fd_q, fd_d;
    logic [NIBBLE_W-1:0] nib_q, nib_d;
    logic [N_DIGITS-1:0] en_q, en_d;
    logic                t_load, t_expire;
    logic [CW-1:0]       t_val;

    seven_seg_slot_timer #(.CW(CW)) u_timer (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Load     (t_load),
        .i_Load_Val (t_val),
        .o_Expire   (t_expire)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        fd_d     = 1'b0;
        t_load   = 1'b0;
        t_val    = CW'(BLANK_CYCLES);
        shadow_d = shadow_q;
        hold_d   = hold_q;
        pend_d   = pend_q;
        if (!i_Enable) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (state_q == IDLE) begin
            state_d = BLANK;
            idx_d   = '0;
            t_load  = 1'b1;
        end else if (t_expire) begin
            t_load  = 1'b1;
            state_d = (state_q == BLANK) ? DRIVE : BLANK;
            t_val   = (state_q == BLANK) ? CW'(DRIVE_CYCLES) : CW'(BLANK_CYCLES);
            fd_d    = (state_q == DRIVE) && (idx_q == IW'(N_DIGITS - 1));
            idx_d   = (state_q == BLANK) ? idx_q : (fd_d ? '0 : idx_q + IW'(1));
        end
        // The wrap cycle is the frame-done cycle; shadow swaps only there or while idle.
        if (i_Value_Load && fd_q) begin
            shadow_d = i_Value;
            hold_d   = i_Value;
            pend_d   = 1'b0;
        end else begin
            if (pend_q && (fd_q || state_q == IDLE)) begin
                shadow_d = hold_q;
                pend_d   = 1'b0;
            end
            if (i_Value_Load) begin
                hold_d = i_Value;
                pend_d = 1'b1;
            end
        end
        nib_d = nib_sel(32'(shadow_d), 3'(idx_d));
`ifdef LEADING_ZERO_BLANK_EN
        en_d = (state_d == DRIVE && 3'(idx_d) <= msd_idx(32'(shadow_d))) ? N_DIGITS'(1) << idx_d : '0;
`else
        en_d = (state_d == DRIVE) ? N_DIGITS'(1) << idx_d : '0;
`endif
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
            hold_q   <= '0;
            pend_q   <= 1'b0;
            fd_q     <= 1'b0;
            nib_q    <= '0;
            en_q     <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            hold_q   <= hold_d;
            pend_q   <= pend_d;
            fd_q     <= fd_d;
            nib_q    <= nib_d;
            en_q     <= en_d;
        end
    end

    assign o_Load_Pending = pend_q;
    assign o_Nibble       = nib_q;
    assign o_Digit_En     = en_q;
    assign o_Frame_Done   = fd_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed table-driven bench for seven_seg_scan_ctrl (N=4, DRIVE=4, BLANK=2).
// Builds with or without LEADING_ZERO_BLANK_EN; expectations follow the macro.
module tb_seven_seg_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_i = 1'b0;
    logic [15:0] val = '0;
    logic        ld = 1'b0;
    logic        pend;
    logic [3:0]  nib;
    logic [3:0]  den;
    logic        fd;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    seven_seg_scan_ctrl #(.N_DIGITS(4), .DRIVE_CYCLES(4), .BLANK_CYCLES(2)) dut (
        .i_Clk          (clk),
        .i_Rst          (rst),
        .i_Enable       (en_i),
        .i_Value        (val),
        .i_Value_Load   (ld),
        .o_Load_Pending (pend),
        .o_Nibble       (nib),
        .o_Digit_En     (den),
        .o_Frame_Done   (fd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          t;
        logic        ld;
        logic [15:0] val;
        logic [3:0]  en;
        logic [3:0]  nib;
        logic        fd;
        logic        pend;
    } vec_t;
    vec_t vt [0:24];

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    task automatic tick();
        @(negedge clk);
        cyc++;
        ld = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    initial begin
        int   fd_first, fd_second, fd_count;
        logic [3:0] seen;
        vt[0]  = '{0,  0, 16'h0, 4'h0, 4'h4, 0, 0};
        vt[1]  = '{1,  0, 16'h0, 4'h0, 4'h4, 0, 0};
        vt[2]  = '{2,  0, 16'h0, 4'h1, 4'h4, 0, 0};
        vt[3]  = '{5,  0, 16'h0, 4'h1, 4'h4, 0, 0};
        vt[4]  = '{6,  0, 16'h0, 4'h0, 4'h3, 0, 0};
        vt[5]  = '{8,  0, 16'h0, 4'h2, 4'h3, 0, 0};
        vt[6]  = '{11, 0, 16'h0, 4'h2, 4'h3, 0, 0};
        vt[7]  = '{14, 0, 16'h0, 4'h4, 4'h2, 0, 0};
        vt[8]  = '{20, 0, 16'h0, 4'h8, 4'h1, 0, 0};
        vt[9]  = '{23, 0, 16'h0, 4'h8, 4'h1, 0, 0};
        vt[10] = '{24, 0, 16'h0, 4'h0, 4'h4, 1, 0};
        vt[11] = '{25, 0, 16'h0, 4'h0, 4'h4, 0, 0};
        vt[12] = '{26, 0, 16'h0, 4'h1, 4'h4, 0, 0};
        vt[13] = '{34, 1, 16'hABCD, 4'h2, 4'h3, 0, 0};
        vt[14] = '{35, 0, 16'h0, 4'h2, 4'h3, 0, 1};
        vt[15] = '{38, 0, 16'h0, 4'h4, 4'h2, 0, 1};
        vt[16] = '{44, 0, 16'h0, 4'h8, 4'h1, 0, 1};
        vt[17] = '{48, 0, 16'h0, 4'h0, 4'h4, 1, 1};
        vt[18] = '{49, 0, 16'h0, 4'h0, 4'hD, 0, 0};
        vt[19] = '{50, 0, 16'h0, 4'h1, 4'hD, 0, 0};
        vt[20] = '{56, 0, 16'h0, 4'h2, 4'hC, 0, 0};
        vt[21] = '{72, 1, 16'h00F0, 4'h0, 4'hD, 1, 0};
        vt[22] = '{73, 0, 16'h0, 4'h0, 4'h0, 0, 0};
        vt[23] = '{75, 0, 16'h0, 4'h1, 4'h0, 0, 0};
        vt[24] = '{80, 0, 16'h0, 4'h2, 4'hF, 0, 0};

        // Reset must win over enable and load.
        en_i = 1'b1; ld = 1'b1; val = 16'hFFFF;
        tick();
        tick();
        chk("rst_en", 32'(den), 0);
        chk("rst_nib", 32'(nib), 0);
        chk("rst_fd", 32'(fd), 0);
        chk("rst_pend", 32'(pend), 0);
        rst = 1'b0; en_i = 1'b0;
        tick();
        val = 16'h1234; ld = 1'b1;
        tick();
        chk("idle_pend_set", 32'(pend), 1);
        tick();
        chk("idle_pend_clr", 32'(pend), 0);
        en_i = 1'b1;
        cyc = -1;
        tick();

        for (int i = 0; i < 25; i++) begin
            while (cyc < vt[i].t) tick();
            chk($sformatf("v%0d_en", i), 32'(den), 32'(vt[i].en));
            chk($sformatf("v%0d_nib", i), 32'(nib), 32'(vt[i].nib));
            chk($sformatf("v%0d_fd", i), 32'(fd), 32'(vt[i].fd));
            chk($sformatf("v%0d_pend", i), 32'(pend), 32'(vt[i].pend));
            if (vt[i].ld) begin
                ld = 1'b1;
                val = vt[i].val;
            end
        end

        // Disable mid-DRIVE of digit 2 (00F0 frame, digit 2 drives 86..89).
        while (cyc < 87) tick();
        chk("d2_drive_en", 32'(den), LZB ? 0 : 4);
        chk("d2_drive_nib", 32'(nib), 0);
        en_i = 1'b0;
        tick();
        chk("dis_en", 32'(den), 0);
        while (cyc < 93) tick();
        chk("dis_hold_en", 32'(den), 0);
        chk("dis_hold_fd", 32'(fd), 0);
        en_i = 1'b1;
        cyc = -1;
        tick();
        chk("reen_t0_en", 32'(den), 0);
        chk("reen_t0_nib", 32'(nib), 0);
        tick();
        chk("reen_t1_en", 32'(den), 0);
        tick();
        chk("reen_t2_en", 32'(den), 1);
        val = 16'h5555; ld = 1'b1;
        tick();
        chk("mid_pend", 32'(pend), 1);

        // Reset during DRIVE of digit 1 with a load pending.
        while (cyc < 9) tick();
        chk("d1_drive_en", 32'(den), 2);
        chk("d1_drive_nib", 32'(nib), 4'hF);
        rst = 1'b1;
        tick();
        chk("rst2_en", 32'(den), 0);
        chk("rst2_nib", 32'(nib), 0);
        chk("rst2_fd", 32'(fd), 0);
        chk("rst2_pend", 32'(pend), 0);
        rst = 1'b0;
        cyc = -1;
        tick();
        chk("post_rst_t0_en", 32'(den), 0);
        while (cyc < 6) tick();
        chk("shadow_clr_nib", 32'(nib), 0);
        while (cyc < 8) tick();
        chk("shadow_clr_en", 32'(den), LZB ? 0 : 2);
        chk("post_rst_pend", 32'(pend), 0);

        // Leading-zero case 0050; frame period must be 24 in both builds.
        en_i = 1'b0;
        tick();
        val = 16'h0050; ld = 1'b1;
        tick();
        tick();
        chk("z_pend_clr", 32'(pend), 0);
        en_i = 1'b1;
        cyc = -1;
        tick();
        seen = '0; fd_count = 0; fd_first = -1; fd_second = -1;
        for (int c = 0; c <= 48; c++) begin
            if (c < 24) seen |= den;
            if (fd) begin
                fd_count++;
                if (fd_first < 0) fd_first = cyc; else fd_second = cyc;
            end
            if (c < 48) tick();
        end
        chk("lz_seen_en", 32'(seen), LZB ? 4'h3 : 4'hF);
        chk("lz_fd_count", 32'(fd_count), 2);
        chk("lz_fd_first", 32'(fd_first), 24);
        chk("lz_fd_period", 32'(fd_second - fd_first), 24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
